// File: rtl/memory_arbiter.sv
// Round-robin arbiter between I-cache and D-cache onto a single main-memory port,
// with per-transaction latching, response routing and a SERVE-state watchdog.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned LEN              = 32,
  parameter int unsigned ENTRY_INDEX_SIZE = 3,
  parameter int unsigned WAIT_LIMIT       = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  i_cache_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       i_cache_mem_vis_addr,
  output logic [1:0]                  i_cache_mem_status,
  output logic [LEN-1:0]              i_cache_mem_data,
  input  logic [1:0]                  d_cache_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr,
  input  logic [LEN-1:0]              d_cache_writen_data,
  input  logic [ENTRY_INDEX_SIZE:0]   d_cache_write_length,
  output logic [1:0]                  d_cache_mem_status,
  output logic [LEN-1:0]              d_cache_mem_data,
  output logic [1:0]                  mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
  output logic [LEN-1:0]              mem_writen_data,
  output logic [ENTRY_INDEX_SIZE:0]   mem_length,
  input  logic [LEN-1:0]              mem_data,
  input  logic [1:0]                  mem_status
);

  localparam int unsigned LW = ENTRY_INDEX_SIZE + 1;
  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

  localparam logic [1:0] SIG_READ  = 2'b01;
  localparam logic [1:0] SIG_WRITE = 2'b10;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_BUSY   = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;
  localparam logic [1:0] ST_ERR    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // last_d_q doubles as the current grant owner (1 = D-cache) once a grant is made
  logic                  last_d_q, last_d_d;
  logic [1:0]            lat_sig_q, lat_sig_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [LEN-1:0]        lat_data_q, lat_data_d;
  logic [LW-1:0]         lat_len_q, lat_len_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;

  logic [1:0]            i_status_d, d_status_d, mem_sig_d;
  logic [LEN-1:0]        i_data_d, d_data_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [LW-1:0]         mem_len_d;

  logic i_valid, d_valid, pick_d, mem_done, timeout;

  assign i_valid  = (i_cache_mem_vis_signal == SIG_READ);
  assign d_valid  = (d_cache_mem_vis_signal == SIG_READ) || (d_cache_mem_vis_signal == SIG_WRITE);
  assign pick_d   = d_valid && (!i_valid || !last_d_q);
  assign mem_done = (mem_status == ST_DONE);
  assign timeout  = (wait_cnt_q >= CW'(WAIT_LIMIT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    lat_sig_d   = lat_sig_q;
    lat_addr_d  = lat_addr_q;
    lat_data_d  = lat_data_q;
    lat_len_d   = lat_len_q;
    wait_cnt_d  = wait_cnt_q;
    i_status_d  = i_cache_mem_status;
    d_status_d  = d_cache_mem_status;
    i_data_d    = i_cache_mem_data;
    d_data_d    = d_cache_mem_data;
    mem_sig_d   = mem_vis_signal;
    mem_addr_d  = mem_vis_addr;
    mem_wdata_d = mem_writen_data;
    mem_len_d   = mem_length;

    case (state_q)
      IDLE: begin
        i_status_d = i_valid ? ST_BUSY : ST_IDLE;
        d_status_d = d_valid ? ST_BUSY : ST_IDLE;
        mem_sig_d  = ST_IDLE;
        if (i_valid || d_valid) begin
          state_d    = SERVE;
          last_d_d   = pick_d;
          wait_cnt_d = '0;
          lat_sig_d  = pick_d ? d_cache_mem_vis_signal : SIG_READ;
          lat_addr_d = pick_d ? d_cache_mem_vis_addr : i_cache_mem_vis_addr;
          lat_data_d = pick_d ? d_cache_writen_data : '0;
          lat_len_d  = pick_d ? d_cache_write_length : LW'(1);
        end
      end

      SERVE: begin
        mem_sig_d   = lat_sig_q;
        mem_addr_d  = lat_addr_q;
        mem_wdata_d = lat_data_q;
        mem_len_d   = lat_len_q;
        if (last_d_q) begin
          d_status_d = ST_BUSY;
          i_status_d = i_valid ? ST_BUSY : ST_IDLE;
        end else begin
          i_status_d = ST_BUSY;
          d_status_d = d_valid ? ST_BUSY : ST_IDLE;
        end
        if (wait_cnt_q != CW'(WAIT_LIMIT)) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
        // A done arriving on the last allowed cycle still wins over the timeout
        if (mem_done || timeout) begin
          state_d   = RESP;
          mem_sig_d = ST_IDLE;
          if (last_d_q) begin
            d_status_d = mem_done ? ST_DONE : ST_ERR;
          end else begin
            i_status_d = mem_done ? ST_DONE : ST_ERR;
          end
          if (mem_done && (lat_sig_q == SIG_READ)) begin
            if (last_d_q) begin
              d_data_d = mem_data;
            end else begin
              i_data_d = mem_data;
            end
          end
        end
      end

      RESP: begin
        state_d    = IDLE;
        mem_sig_d  = ST_IDLE;
        wait_cnt_d = '0;
        i_status_d = (last_d_q && i_valid) ? ST_BUSY : ST_IDLE;
        d_status_d = (!last_d_q && d_valid) ? ST_BUSY : ST_IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_sig_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      last_d_q           <= 1'b1;
      lat_sig_q          <= '0;
      lat_addr_q         <= '0;
      lat_data_q         <= '0;
      lat_len_q          <= '0;
      wait_cnt_q         <= '0;
      i_cache_mem_status <= '0;
      d_cache_mem_status <= '0;
      i_cache_mem_data   <= '0;
      d_cache_mem_data   <= '0;
      mem_vis_signal     <= '0;
      mem_vis_addr       <= '0;
      mem_writen_data    <= '0;
      mem_length         <= '0;
    end else begin
      state_q            <= state_d;
      last_d_q           <= last_d_d;
      lat_sig_q          <= lat_sig_d;
      lat_addr_q         <= lat_addr_d;
      lat_data_q         <= lat_data_d;
      lat_len_q          <= lat_len_d;
      wait_cnt_q         <= wait_cnt_d;
      i_cache_mem_status <= i_status_d;
      d_cache_mem_status <= d_status_d;
      i_cache_mem_data   <= i_data_d;
      d_cache_mem_data   <= d_data_d;
      mem_vis_signal     <= mem_sig_d;
      mem_vis_addr       <= mem_addr_d;
      mem_writen_data    <= mem_wdata_d;
      mem_length         <= mem_len_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, hand-written reset/illegal-request
// sequences and randomized transactions checked against a transaction-level model.
module tb_memory_arbiter;

  localparam int unsigned WL = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  i_sig;
  logic [16:0] i_addr;
  logic [1:0]  i_status;
  logic [31:0] i_data;
  logic [1:0]  d_sig;
  logic [16:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_len;
  logic [1:0]  d_status;
  logic [31:0] d_data;
  logic [1:0]  mem_vis_signal;
  logic [16:0] mem_vis_addr;
  logic [31:0] mem_writen_data;
  logic [3:0]  mem_length;
  logic [31:0] mem_data;
  logic [1:0]  mem_status;

  memory_arbiter #(
    .ADDR_WIDTH(17), .LEN(32), .ENTRY_INDEX_SIZE(3), .WAIT_LIMIT(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cache_mem_vis_signal(i_sig), .i_cache_mem_vis_addr(i_addr),
    .i_cache_mem_status(i_status), .i_cache_mem_data(i_data),
    .d_cache_mem_vis_signal(d_sig), .d_cache_mem_vis_addr(d_addr),
    .d_cache_writen_data(d_wdata), .d_cache_write_length(d_len),
    .d_cache_mem_status(d_status), .d_cache_mem_data(d_data),
    .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
    .mem_writen_data(mem_writen_data), .mem_length(mem_length),
    .mem_data(mem_data), .mem_status(mem_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rq_i;
    logic        rq_d;
    logic [1:0]  dsig;
    logic [16:0] iaddr;
    logic [16:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  len;
    int          delay;    // memory asserts done on this many'th cycle it sees the request
    logic [31:0] rdata;
    logic        e_gnt_d;
    int          e_n01;
    logic [1:0]  e_st;
    logic [31:0] e_data;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // transaction-level model state
  logic        m_last_d = 1'b1;
  logic [31:0] m_i_data = '0;
  logic [31:0] m_d_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idle_i();
    case ($urandom_range(0, 2))
      0: return 2'b00;
      1: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] idle_d();
    return $urandom_range(0, 1) ? 2'b11 : 2'b00;
  endfunction

  // Drive one transaction from an IDLE cycle to the IDLE cycle after its response
  task automatic run_txn(input vec_t v, input logic withdraw);
    logic [1:0]  gst, ost, esig;
    logic [16:0] eaddr;
    logic [31:0] ewd, edat;
    logic [3:0]  elen;
    logic        opend, fin;
    int          n01, seen;
    esig  = v.e_gnt_d ? v.dsig : 2'b01;
    eaddr = v.e_gnt_d ? v.daddr : v.iaddr;
    ewd   = v.e_gnt_d ? v.wdata : 32'h0;
    elen  = v.e_gnt_d ? v.len : 4'd1;
    opend = v.e_gnt_d ? v.rq_i : v.rq_d;
    i_sig = v.rq_i ? 2'b01 : idle_i();
    i_addr = v.iaddr;
    d_sig = v.rq_d ? v.dsig : idle_d();
    d_addr = v.daddr;
    d_wdata = v.wdata;
    d_len = v.len;
    n01 = 0; seen = 0; fin = 1'b0; gst = 2'b00;
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge clk);
      gst = v.e_gnt_d ? d_status : i_status;
      ost = v.e_gnt_d ? i_status : d_status;
      chk("other_status", 32'(ost), opend ? 32'h1 : 32'h0);
      if (gst == 2'b01) begin
        n01++;
        chk("mem_vis_signal", 32'(mem_vis_signal), (c >= 2) ? 32'(esig) : 32'h0);
        if (c >= 2) begin
          chk("mem_vis_addr", 32'(mem_vis_addr), 32'(eaddr));
          chk("mem_writen_data", mem_writen_data, ewd);
          chk("mem_length", 32'(mem_length), 32'(elen));
        end
      end else begin
        fin = 1'b1;
      end
      if (withdraw && c == 1) begin
        if (v.e_gnt_d) d_sig = 2'($urandom);
        else i_sig = 2'($urandom);
      end
      if (mem_vis_signal != 2'b00) seen++;
      if (!fin && mem_vis_signal != 2'b00 && seen == v.delay) begin
        mem_status = 2'b10;
        mem_data = v.rdata;
      end else begin
        mem_status = 2'($urandom_range(0, 1));
        mem_data = $urandom;
      end
    end
    mem_status = 2'b00;
    edat = v.e_gnt_d ? d_data : i_data;
    chk("completed_in_bound", 32'(fin), 32'h1);
    chk("final_status", 32'(gst), 32'(v.e_st));
    chk("busy_cycles", 32'(n01), 32'(v.e_n01));
    chk("resp_data", edat, v.e_data);
    chk("resp_mem_vis_signal", 32'(mem_vis_signal), 32'h0);
    if (v.e_gnt_d) d_sig = 2'b00;
    else i_sig = 2'b00;
    @(negedge clk);
    gst = v.e_gnt_d ? d_status : i_status;
    ost = v.e_gnt_d ? i_status : d_status;
    chk("post_resp_status", 32'(gst), 32'h0);
    chk("post_resp_other", 32'(ost), opend ? 32'h1 : 32'h0);
    chk("post_resp_mem_vis", 32'(mem_vis_signal), 32'h0);
  endtask

  // Build expectations from the arbitration/watchdog rules, run, update model
  task automatic do_txn(input logic rq_i, input logic rq_d, input logic [1:0] dsig,
                        input int delay, input logic [31:0] rdata, input logic withdraw);
    vec_t v;
    logic ok;
    v.rq_i = rq_i; v.rq_d = rq_d; v.dsig = dsig;
    v.iaddr = 17'($urandom); v.daddr = 17'($urandom);
    v.wdata = $urandom; v.len = 4'($urandom);
    v.delay = delay; v.rdata = rdata;
    v.e_gnt_d = rq_d && (!rq_i || !m_last_d);
    ok = (delay < int'(WL));
    v.e_n01 = ok ? delay + 1 : int'(WL);
    v.e_st = ok ? 2'b10 : 2'b11;
    if (ok && (!v.e_gnt_d || dsig == 2'b01)) v.e_data = rdata;
    else v.e_data = v.e_gnt_d ? m_d_data : m_i_data;
    run_txn(v, withdraw);
    m_last_d = v.e_gnt_d;
    if (v.e_gnt_d) m_d_data = v.e_data;
    else m_i_data = v.e_data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_status"}, 32'(i_status), 32'h0);
    chk({tag, "_d_status"}, 32'(d_status), 32'h0);
    chk({tag, "_i_data"}, i_data, 32'h0);
    chk({tag, "_d_data"}, d_data, 32'h0);
    chk({tag, "_mem_vis_signal"}, 32'(mem_vis_signal), 32'h0);
    chk({tag, "_mem_vis_addr"}, 32'(mem_vis_addr), 32'h0);
    chk({tag, "_mem_writen_data"}, mem_writen_data, 32'h0);
    chk({tag, "_mem_length"}, 32'(mem_length), 32'h0);
  endtask

  vec_t tbl[8];

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic rq_i, rq_d;
    logic [1:0] dsig;
    int kind;

    tbl[0] = '{1'b0, 1'b1, 2'b01, 17'h00000, 17'h00100, 32'h0, 4'd1, 3, 32'hDEADBEEF,
               1'b1, 4, 2'b10, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 2'b10, 17'h00000, 17'h00040, 32'h12345678, 4'd4, 2, 32'h5555AAAA,
               1'b1, 3, 2'b10, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 2'b01, 17'h1F000, 17'h00000, 32'h0, 4'd1, 1, 32'h0000A5A5,
               1'b0, 2, 2'b10, 32'h0000A5A5};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 17'h00000, 17'h00200, 32'h0, 4'd2, 20, 32'h11111111,
               1'b1, 8, 2'b11, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b0, 2'b01, 17'h00004, 17'h00000, 32'h0, 4'd1, 7, 32'h0BADF00D,
               1'b0, 8, 2'b10, 32'h0BADF00D};
    tbl[5] = '{1'b1, 1'b0, 2'b01, 17'h00008, 17'h00000, 32'h0, 4'd1, 8, 32'h22222222,
               1'b0, 8, 2'b11, 32'h0BADF00D};
    tbl[6] = '{1'b0, 1'b1, 2'b10, 17'h00000, 17'h1FFFC, 32'hFFFFFFFF, 4'd15, 1, 32'h66666666,
               1'b1, 2, 2'b10, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 1'b1, 2'b01, 17'h00010, 17'h00020, 32'h0, 4'd3, 2, 32'h33333333,
               1'b0, 3, 2'b10, 32'h33333333};

    rst = 1'b1;
    i_sig = '0; i_addr = '0; d_sig = '0; d_addr = '0; d_wdata = '0; d_len = '0;
    mem_data = '0; mem_status = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // I-cache write encoding is illegal and must be ignored
    i_sig = 2'b10; i_addr = 17'h00ABC;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("iwrite_i_status", 32'(i_status), 32'h0);
      chk("iwrite_mem_vis", 32'(mem_vis_signal), 32'h0);
    end
    i_sig = 2'b00;

    for (int n = 0; n < 8; n++) begin
      run_txn(tbl[n], 1'b0);
      m_last_d = tbl[n].e_gnt_d;
      if (tbl[n].e_gnt_d) m_d_data = tbl[n].e_data;
      else m_i_data = tbl[n].e_data;
      if (tbl[n].rq_i && tbl[n].rq_d) do_txn(!tbl[n].e_gnt_d, tbl[n].e_gnt_d ? 1'b0 : 1'b1,
                                             tbl[n].dsig, 4, 32'h44444444, 1'b0);
    end

    // reset in the middle of SERVE aborts with everything cleared
    d_sig = 2'b01; d_addr = 17'h00300;
    mem_status = 2'b01;
    repeat (4) @(negedge clk);
    chk("pre_reset_d_status", 32'(d_status), 32'h1);
    rst = 1'b1; d_sig = 2'b00; mem_status = 2'b00;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    m_last_d = 1'b1; m_i_data = '0; m_d_data = '0;

    // simultaneous requests after reset: I first, then D
    do_txn(1'b1, 1'b1, 2'b01, 2, 32'h77777777, 1'b0);
    do_txn(1'b0, 1'b1, 2'b01, 3, 32'h88888888, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      rq_i = (kind == 0) || (kind == 3);
      rq_d = (kind != 0);
      dsig = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      do_txn(rq_i, rq_d, dsig, $urandom_range(1, 10), $urandom, 1'($urandom_range(0, 1)));
      if (rq_i && rq_d) begin
        do_txn(!m_last_d, m_last_d ? 1'b0 : 1'b1, dsig, $urandom_range(1, 10), $urandom, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
